// File: rtl/ksa_pkg.sv
// ---------------------------------------------------------------------------
// ksa_pkg
//   Shared definitions for the RC4 key-scheduling engine:
//     - ksa_state_e : FSM state encodings (4-bit, values fixed so that
//                     waveforms and external debug tools can decode them)
//     - KEY_BYTES   : number of key bytes cycled through by the schedule
//     - key_byte()  : picks key byte K[i mod 3] out of the packed 24-bit key
// ---------------------------------------------------------------------------
package ksa_pkg;

  localparam int KEY_BYTES = 3;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int KEY_W     = KEY_BYTES * DATA_W;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RDI1   = 4'd1,
    ST_RDI2   = 4'd2,
    ST_CALCJ  = 4'd3,
    ST_RDJ1   = 4'd4,
    ST_RDJ2   = 4'd5,
    ST_WRTI1  = 4'd6,
    ST_WRTI2  = 4'd7,
    ST_WRTJ1  = 4'd8,
    ST_WRTJ2  = 4'd9,
    ST_INCREI = 4'd10,
    ST_LOOP   = 4'd11,
    ST_START  = 4'd12
  } ksa_state_e;

  // Key byte for iteration idx. K0 is the most significant byte of the key.
  function automatic logic [DATA_W-1:0] key_byte(input logic [KEY_W-1:0]  key,
                                                 input logic [ADDR_W-1:0] idx);
    logic [1:0] sel;
    sel = 2'(idx % 8'(KEY_BYTES));
    case (sel)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ksa.sv
// ---------------------------------------------------------------------------
// ksa
//   RC4 key-scheduling engine. Walks i = 0..255 over a 256x8 state array S
//   held in an external single-port memory (already initialised to S[k]=k),
//   computing j = j + S[i] + K[i mod 3] and swapping S[i] and S[j].
//   Every iteration takes 11 cycles: read S[i], compute j, read S[j],
//   write S[i], write S[j], advance i.
//
// Ports
//   clk     : rising-edge clock
//   rst     : synchronous, active-high reset (aborts a run, returns to IDLE)
//   en      : start request, only looked at in IDLE
//   rdy     : high while idle / able to accept en
//   key     : 24-bit key, K0 = key[23:16], K1 = key[15:8], K2 = key[7:0]
//   addr    : registered memory address
//   rddata  : memory read data for the address presented by addr
//   wrdata  : registered memory write data
//   wren    : registered write strobe, memory writes on the closing edge
// ---------------------------------------------------------------------------
module ksa
  import ksa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  key,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren
);

  ksa_state_e        state_q,   state_d;
  logic [ADDR_W-1:0] count_i_q, count_i_d;
  logic [ADDR_W-1:0] count_j_q, count_j_d;
  logic [DATA_W-1:0] tmp_si_q,  tmp_si_d;
  logic [DATA_W-1:0] tmp_sj_q,  tmp_sj_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wrdata_q,  wrdata_d;
  logic              wren_q,    wren_d;
  logic              rdy_q,     rdy_d;

  // -------------------------------------------------------------------------
  // State register. All outputs come straight from flops, so the combinational
  // block below computes the value each output must carry in the *next* state.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_i_q <= '0;
      count_j_q <= '0;
      tmp_si_q  <= '0;
      tmp_sj_q  <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      wren_q    <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_i_q <= count_i_d;
      count_j_q <= count_j_d;
      tmp_si_q  <= tmp_si_d;
      tmp_sj_q  <= tmp_sj_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wren_q    <= wren_d;
      rdy_q     <= rdy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic.
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    count_i_d = count_i_q;
    count_j_d = count_j_q;
    tmp_si_d  = tmp_si_q;
    tmp_sj_d  = tmp_sj_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    wren_d    = 1'b0;
    rdy_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy_d    = 1'b1;
        addr_d   = '0;
        wrdata_d = '0;
        if (en) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        // First read of S[i] goes out on the next cycle.
        state_d = ST_RDI1;
        addr_d  = count_i_q;
      end

      ST_RDI1: begin
        state_d = ST_RDI2;
        addr_d  = count_i_q;
      end

      ST_RDI2: begin
        // rddata is S[i] for the address held over RDI1/RDI2.
        state_d   = ST_CALCJ;
        addr_d    = count_i_q;
        tmp_si_d  = rddata;
        count_j_d = count_j_q + rddata + key_byte(key, count_i_q);
      end

      ST_CALCJ: begin
        state_d = ST_RDJ1;
        addr_d  = count_j_q;
      end

      ST_RDJ1: begin
        state_d = ST_RDJ2;
        addr_d  = count_j_q;
      end

      ST_RDJ2: begin
        // S[j] lands in tmp_sj and is also the value written back to S[i];
        // rddata is used directly because tmp_sj only updates on this edge.
        state_d  = ST_WRTI1;
        tmp_sj_d = rddata;
        addr_d   = count_i_q;
        wrdata_d = rddata;
      end

      ST_WRTI1: begin
        state_d  = ST_WRTI2;
        addr_d   = count_i_q;
        wrdata_d = tmp_sj_q;
        wren_d   = 1'b1;
      end

      ST_WRTI2: begin
        state_d  = ST_WRTJ1;
        addr_d   = count_j_q;
        wrdata_d = tmp_si_q;
      end

      ST_WRTJ1: begin
        state_d  = ST_WRTJ2;
        addr_d   = count_j_q;
        wrdata_d = tmp_si_q;
        wren_d   = 1'b1;
      end

      ST_WRTJ2: begin
        // When i == j the two writes hit the same location with the same
        // value (tmp_si == tmp_sj), so the swap degenerates to a no-op.
        state_d  = ST_INCREI;
        addr_d   = '0;
        wrdata_d = '0;
      end

      ST_INCREI: begin
        state_d   = ST_LOOP;
        count_i_d = count_i_q + 8'd1;
      end

      ST_LOOP: begin
        // count_i wraps to 0 only after the i = 255 iteration completes.
        if (count_i_q == '0) begin
          state_d   = ST_IDLE;
          count_j_d = '0;
          rdy_d     = 1'b1;
        end else begin
          state_d = ST_RDI1;
          addr_d  = count_i_q;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        count_i_d = '0;
        count_j_d = '0;
        addr_d    = '0;
        wrdata_d  = '0;
        rdy_d     = 1'b1;
      end
    endcase

    // Entering START keeps rdy high for that one cycle.
    if (state_d == ST_START) begin
      rdy_d = 1'b1;
    end
  end

  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;
  assign rdy    = rdy_q;

endmodule

// File: tb/tb_ksa.sv
// ---------------------------------------------------------------------------
// tb_ksa
//   Self-checking bench for the RC4 key-scheduling engine. A 256x8 memory with
//   combinational read is re-initialised to S[k]=k on every reset cycle. Final
//   memory contents are compared to a plain software RC4 key schedule.
// ---------------------------------------------------------------------------
module tb_ksa;
  import ksa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  logic [7:0]  mem   [256];
  logic [7:0]  ref_s [256];

  int total = 0;
  int bad   = 0;
  int writes;
  int cycles;

  always #5 clk = ~clk;

  assign rddata = mem[addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
  end

  ksa dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Textbook RC4 key schedule with a 3-byte key.
  task automatic rc4_ksa(input logic [23:0] k);
    logic [7:0] kb [3];
    logic [7:0] t;
    int j;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int i = 0; i < 256; i++) ref_s[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(ref_s[i]) + int'(kb[i % 3])) % 256;
      t        = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic check_mem(input string tag, input logic [23:0] k);
    rc4_ksa(k);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("%s S[%0d]", tag, i), 32'(mem[i]), 32'(ref_s[i]));
    end
  endtask

  // Advance until the engine is back in IDLE, counting cycles and write strobes.
  task automatic wait_idle(input string tag, input int budget);
    cycles = 0;
    while (dut.state_q != ST_IDLE && cycles < budget) begin
      if (wren) writes++;
      step();
      cycles++;
    end
    check({tag, " timeout"}, 32'(cycles < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [7:0] gold_lo [8];
  logic [7:0] gold_hi [8];
  logic [23:0] rkey;

  initial begin
    gold_lo = '{8'hb4, 8'h04, 8'h2b, 8'he5, 8'h49, 8'h0a, 8'h90, 8'h9a};
    gold_hi = '{8'h50, 8'h52, 8'hee, 8'h3b, 8'h5c, 8'h37, 8'he6, 8'h1b};
    rst = 1'b1;
    en  = 1'b0;
    key = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst state",  32'(dut.state_q), 32'(ST_IDLE));
    check("rst rdy",    32'(rdy),         32'd1);
    check("rst wren",   32'(wren),        32'd0);
    check("rst addr",   32'(addr),        32'd0);
    check("rst wrdata", 32'(wrdata),      32'd0);
    check("rst i",      32'(dut.count_i_q), 32'd0);
    check("rst j",      32'(dut.count_j_q), 32'd0);

    // First iteration of key 00033C, step by step (i = j = 0 self-swap)
    key = 24'h00033C;
    en  = 1'b1;
    step();
    check("start state", 32'(dut.state_q), 32'(ST_START));
    check("start rdy",   32'(rdy),         32'd1);
    en = 1'b0;
    step();
    check("rdi1 state",  32'(dut.state_q), 32'(ST_RDI1));
    check("rdi1 rdy",    32'(rdy),         32'd0);
    check("rdi1 addr",   32'(addr),        32'd0);
    step();
    check("rdi2 state",  32'(dut.state_q), 32'(ST_RDI2));
    step();
    check("calcj state", 32'(dut.state_q), 32'(ST_CALCJ));
    check("calcj j",     32'(dut.count_j_q), 32'd0);
    step();
    check("rdj1 addr",   32'(addr),        32'd0);
    step();
    check("rdj2 state",  32'(dut.state_q), 32'(ST_RDJ2));
    check("rdj2 addr",   32'(addr),        32'd0);
    step();
    check("wrti1 wren",  32'(wren),        32'd0);
    step();
    check("wrti2 state", 32'(dut.state_q), 32'(ST_WRTI2));
    check("wrti2 wren",  32'(wren),        32'd1);
    check("wrti2 addr",  32'(addr),        32'd0);
    step();
    check("wrtj1 wren",  32'(wren),        32'd0);
    step();
    check("wrtj2 state", 32'(dut.state_q), 32'(ST_WRTJ2));
    check("wrtj2 wren",  32'(wren),        32'd1);
    check("wrtj2 addr",  32'(addr),        32'd0);
    step();
    check("increi state", 32'(dut.state_q), 32'(ST_INCREI));
    check("increi wren",  32'(wren),        32'd0);
    step();
    check("loop state",  32'(dut.state_q), 32'(ST_LOOP));
    check("loop i",      32'(dut.count_i_q), 32'd1);

    // Remainder of the run: START + 256*11 cycles from en to IDLE in total
    writes = 2;
    wait_idle("run0", 4000);
    check("run0 cycles", 32'(cycles),         32'd2806);
    check("run0 writes", 32'(writes),         32'd512);
    check("done rdy",    32'(rdy),            32'd1);
    check("done i",      32'(dut.count_i_q),  32'd0);
    check("done j",      32'(dut.count_j_q),  32'd0);
    step();
    check("idle hold",   32'(dut.state_q),    32'(ST_IDLE));
    check("idle wren",   32'(wren),           32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("gold lo %0d", k), 32'(mem[k]),       32'(gold_lo[k]));
      check($sformatf("gold hi %0d", k), 32'(mem[248 + k]), 32'(gold_hi[k]));
    end
    check_mem("run0", 24'h00033C);

    // Reset in the middle of a run
    do_reset();
    key = 24'($urandom);
    en  = 1'b1;
    step();
    en = 1'b0;
    cycles = 0;
    while (!(dut.state_q == ST_WRTI2 && dut.count_i_q == 8'd5) && cycles < 200) begin
      step();
      cycles++;
    end
    check("midrun reach", 32'(cycles < 200), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort state", 32'(dut.state_q), 32'(ST_IDLE));
    check("abort rdy",   32'(rdy),         32'd1);
    check("abort wren",  32'(wren),        32'd0);
    check("abort addr",  32'(addr),        32'd0);

    // Fresh run after the abort starts again from i = 0
    rkey = 24'($urandom);
    key  = rkey;
    en   = 1'b1;
    step();
    en = 1'b0;
    step();
    check("restart addr", 32'(addr),           32'd0);
    check("restart i",    32'(dut.count_i_q),  32'd0);
    writes = 0;
    wait_idle("run1", 4000);
    check("run1 cycles", 32'(cycles), 32'd2816);
    check("run1 writes", 32'(writes), 32'd512);
    check_mem("run1", rkey);

    // Random key with en held high for the whole run: ignored mid-run,
    // and a new run starts immediately once back in IDLE.
    do_reset();
    rkey = 24'($urandom);
    key  = rkey;
    en   = 1'b1;
    step();
    step();
    writes = 0;
    wait_idle("run2", 4000);
    check("run2 cycles", 32'(cycles), 32'd2816);
    check("run2 writes", 32'(writes), 32'd512);
    check_mem("run2", rkey);
    step();
    check("en held restart", 32'(dut.state_q), 32'(ST_START));
    en = 1'b0;
    do_reset();
    check("final state", 32'(dut.state_q), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
